// File: rtl/sar_search.sv
// Successive-approximation search controller driving a combinational magnitude comparator.
// One compare per cycle, MSB first; early exit on eq, err pulse on a non-one-hot response.
module sar_search #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     gt,
  input  logic                     lt,
  input  logic                     eq,
  output logic [WIDTH-1:0]         trial,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [$clog2(WIDTH):0]   steps,
  output logic                     err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [KW-1:0]    KTOP = KW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  acc, acc_n, acc_upd;
  logic [KW-1:0]     k, k_n, k_dec;
  logic [SW-1:0]     cnt, cnt_n;
  logic [WIDTH-1:0]  trial_n, result_n;
  logic [SW-1:0]     steps_n;
  logic              busy_n, done_n, err_n, onehot;

  assign onehot  = (3'(gt) + 3'(lt) + 3'(eq)) == 3'd1;
  assign acc_upd = lt ? (acc | (ONE << k)) : acc;
  assign k_dec   = k - KW'(1);

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    k_n      = k;
    cnt_n    = cnt;
    trial_n  = trial;
    result_n = result;
    steps_n  = steps;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        trial_n = '0;
        busy_n  = 1'b0;
        if (start) begin
          state_n = SEARCH;
          acc_n   = '0;
          k_n     = KTOP;
          cnt_n   = SW'(1);
          trial_n = ONE << KTOP;
          busy_n  = 1'b1;
        end
      end
      SEARCH: begin
        if (!onehot) begin
          state_n = IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          trial_n = '0;
        end else if (eq) begin
          state_n  = DONE;
          result_n = trial;
          steps_n  = cnt;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          trial_n  = '0;
        end else if (k == '0) begin
          // Last bit decided: the updated accumulator is the answer.
          state_n  = DONE;
          result_n = acc_upd;
          steps_n  = cnt;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          trial_n  = '0;
        end else begin
          acc_n   = acc_upd;
          k_n     = k_dec;
          cnt_n   = cnt + SW'(1);
          trial_n = acc_upd | (ONE << k_dec);
        end
      end
      default: begin
        state_n = IDLE;
        trial_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= '0;
      cnt    <= '0;
      trial  <= '0;
      result <= '0;
      steps  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      k      <= k_n;
      cnt    <= cnt_n;
      trial  <= trial_n;
      result <= result_n;
      steps  <= steps_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator plus a binary-search reference model.
module tb_sar_search;

  logic        clk = 1'b0;
  logic        rst, start, gt, lt, eq, busy, done, err, bad;
  logic [15:0] trial, result, target;
  logic [4:0]  steps;
  int          vecs = 0;
  int          errs = 0;
  logic [15:0] exp_path[$];
  logic [15:0] prev_r;
  logic [4:0]  prev_s;

  always #5 clk = ~clk;

  // Comparator under the bench's control; bad forces an illegal gt+lt response.
  always_comb begin
    if (bad) begin
      gt = 1'b1; lt = 1'b1; eq = 1'b0;
    end else begin
      gt = trial > target;
      lt = trial < target;
      eq = trial == target;
    end
  end

  sar_search #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .trial(trial), .busy(busy), .done(done), .result(result),
    .steps(steps), .err(err)
  );

  // Halving search over [0, 2^16): each trial sets the next bit below the
  // current floor; stop at the first exact hit.
  function automatic void model(input logic [15:0] tgt, output logic [15:0] r, output int n);
    logic [15:0] floor_v, t;
    exp_path.delete();
    floor_v = 16'h0000;
    r = 16'h0000;
    n = 0;
    for (int b = 15; b >= 0; b--) begin
      t = floor_v + (16'h1 << b);
      exp_path.push_back(t);
      n++;
      if (t == tgt) begin
        r = t;
        return;
      end
      if (t < tgt) floor_v = t;
    end
    r = floor_v;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(posedge clk); #1;
    while ((busy || done) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic run_search(input logic [15:0] tgt, input int hold, input string name);
    logic [15:0] er;
    int en, cyc, nb;
    bit got, tbad;
    model(tgt, er, en);
    wait_idle();
    target = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    cyc = 0; nb = 0; got = 0; tbad = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (busy) begin
        if (nb >= en || trial !== exp_path[nb]) tbad = 1;
        nb++;
      end
      if (done) got = 1;
    end
    vecs++; if (!got) begin errs++; $display("FAIL %s done_seen: got 0 want 1", name); end
    vecs++; if (cyc != en + 1) begin errs++; $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, en + 1); end
    vecs++; if (nb != en) begin errs++; $display("FAIL %s busy_cycles: got %0d want %0d", name, nb, en); end
    vecs++; if (tbad) begin errs++; $display("FAIL %s trial_path: deviates from expected sequence for target %h", name, tgt); end
    vecs++; if (result !== er) begin errs++; $display("FAIL %s result: got %h want %h", name, result, er); end
    vecs++; if (steps !== 5'(en)) begin errs++; $display("FAIL %s steps: got %0d want %0d", name, steps, en); end
    prev_r = er;
    prev_s = 5'(en);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bad = 1'b0; target = 16'h0000;
    #3;
    vecs++;
    if ({trial, busy, done, result, steps, err} !== 40'h0) begin
      errs++;
      $display("FAIL reset_values: trial=%h busy=%b done=%b result=%h steps=%0d err=%b want all zero",
               trial, busy, done, result, steps, err);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    run_search(16'h8000, 0, "t8000");
    vecs++; if (steps !== 5'd1) begin errs++; $display("FAIL t8000_steps_const: got %0d want 1", steps); end
    run_search(16'h0000, 0, "t0000");
    vecs++; if (result !== 16'h0000 || steps !== 5'd16) begin errs++; $display("FAIL t0000_const: got %h/%0d want 0000/16", result, steps); end
    run_search(16'hFFFF, 0, "tFFFF");
    vecs++; if (result !== 16'hFFFF || steps !== 5'd16) begin errs++; $display("FAIL tFFFF_const: got %h/%0d want ffff/16", result, steps); end
    run_search(16'h1234, 0, "t1234");
  endtask

  task automatic test_random();
    logic [15:0] t;
    for (int i = 0; i < 1000; i++) begin
      t = 16'($urandom);
      run_search(t, 0, "random");
      vecs++; if (result !== t) begin errs++; $display("FAIL random_eq_target: got %h want %h", result, t); end
    end
  endtask

  task automatic test_protocol_err();
    logic [15:0] pr;
    logic [4:0]  ps;
    bit seen;
    pr = prev_r; ps = prev_s;
    wait_idle();
    target = 16'h0123;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    bad = 1'b1;
    @(negedge clk);
    bad = 1'b0;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_pulse: got %b want 1", err); end
    vecs++; if (busy !== 1'b0 || done !== 1'b0 || trial !== 16'h0) begin errs++; $display("FAIL err_outputs: busy=%b done=%b trial=%h want 0/0/0000", busy, done, trial); end
    vecs++; if (result !== pr || steps !== ps) begin errs++; $display("FAIL err_hold: got %h/%0d want %h/%0d", result, steps, pr, ps); end
    @(negedge clk);
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_one_cycle: got %b want 0", err); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) seen = 1; end
    vecs++; if (seen) begin errs++; $display("FAIL err_no_done: got activity want idle"); end
  endtask

  task automatic test_start_busy();
    run_search(16'h3C3D, 6, "start_busy");
  endtask

  task automatic test_back_to_back();
    logic [15:0] tg[3];
    logic [15:0] rs[3];
    logic [15:0] er;
    int n[3];
    int dc[3];
    int idx, cyc;
    tg[0] = 16'hA5A5; tg[1] = 16'h8000; tg[2] = 16'h0007;
    for (int i = 0; i < 3; i++) model(tg[i], er, n[i]);
    wait_idle();
    target = tg[0];
    start = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 3 && cyc < 200) begin
      @(negedge clk);
      if (done) begin
        dc[idx] = cyc;
        rs[idx] = result;
        idx++;
        if (idx < 3) target = tg[idx];
        else start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    vecs++; if (idx != 3) begin errs++; $display("FAIL b2b_count: got %0d want 3", idx); end
    else begin
      vecs++; if (dc[0] != n[0] + 1) begin errs++; $display("FAIL b2b_first: got %0d want %0d", dc[0], n[0] + 1); end
      for (int i = 1; i < 3; i++) begin
        vecs++; if (dc[i] - dc[i-1] != n[i] + 2) begin errs++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, dc[i] - dc[i-1], n[i] + 2); end
      end
      for (int i = 0; i < 3; i++) begin
        vecs++; if (rs[i] !== tg[i]) begin errs++; $display("FAIL b2b_result%0d: got %h want %h", i, rs[i], tg[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    wait_idle();
    target = 16'h5A5A;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({trial, busy, done, result, steps, err} !== 40'h0) begin
      errs++;
      $display("FAIL reset_mid: trial=%h busy=%b done=%b result=%h steps=%0d err=%b want all zero",
               trial, busy, done, result, steps, err);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (done || err || busy) seen = 1; end
    vecs++; if (seen) begin errs++; $display("FAIL reset_quiet: got activity want none"); end
    run_search(16'h00FF, 0, "post_rst");
    vecs++; if (result !== 16'h00FF || steps !== 5'd16) begin errs++; $display("FAIL post_rst_const: got %h/%0d want 00ff/16", result, steps); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_protocol_err();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
